// File: rtl/chien_search_serial.sv
// Serial-load Chien search over GF(2^M): captures Lambda(x) one coefficient per cycle,
// then tests one field position per cycle using constant-multiplier register updates.
module chien_search_serial #(
    parameter int M      = 13,
    parameter int T      = 32,
    parameter int N      = 8191,
    parameter int OFFSET = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         loc_start,
    input  logic [M-1:0] loc_coef,
    output logic         busy,
    output logic         err_valid,
    output logic [M-1:0] err_pos,
    output logic         err_flag,
    output logic         done,
    output logic [5:0]   err_cnt,
    output logic [5:0]   loc_deg,
    output logic         fail
);

    localparam int           PRIM_POLY = 'h201B;
    localparam logic [M-1:0] POLY_LO   = M'(PRIM_POLY);
    localparam int           ORDER     = (1 << M) - 1;
    localparam int           LCNT_W    = $clog2(T + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
        return v[M-1] ? ({v[M-2:0], 1'b0} ^ POLY_LO) : {v[M-2:0], 1'b0};
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] v;
        v = M'(1);
        for (int i = 0; i < e % ORDER; i++) v = mul_alpha(v);
        return v;
    endfunction

    // Column b of the matrix is alpha^(e+b): the image of basis bit b under x*alpha^e.
    function automatic logic [M*M-1:0] const_mat(input int e);
        logic [M*M-1:0] mat;
        for (int b = 0; b < M; b++) mat[b*M +: M] = alpha_pow(e + b);
        return mat;
    endfunction

    function automatic logic [M-1:0] mul_const(input logic [M-1:0] x, input logic [M*M-1:0] mat);
        logic [M-1:0] acc;
        acc = '0;
        for (int b = 0; b < M; b++) if (x[b]) acc ^= mat[b*M +: M];
        return acc;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == 6'd63) ? c : c + 6'd1;
    endfunction

    state_t            state, state_nxt;
    logic              start_acc;
    logic [LCNT_W-1:0] load_cnt;
    logic [M-1:0]      k_cnt;
    logic [M-1:0]      r0;
    logic [M-1:0]      terms [0:T];
    logic [M-1:0]      sum;
    logic              vld_p0, zero_p0;
    logic [M-1:0]      pos_p0;
    logic              done_arm;

    assign terms[0] = r0;

    for (genvar j = 1; j <= T; j++) begin : g_coef
        localparam logic [M*M-1:0] LOAD_MAT = const_mat(j * OFFSET);
        localparam logic [M*M-1:0] STEP_MAT = const_mat(j);
        logic [M-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (state == LOAD && load_cnt == LCNT_W'(j))
                r_q <= mul_const(loc_coef, LOAD_MAT);
            else if (state == SEARCH)
                r_q <= mul_const(r_q, STEP_MAT);
        end

        assign terms[j] = r_q;
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j <= T; j++) sum ^= terms[j];
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                start_acc = loc_start && !busy;
                if (start_acc) state_nxt = LOAD;
            end
            LOAD:    if (load_cnt == LCNT_W'(T)) state_nxt = SEARCH;
            SEARCH:  if (k_cnt == M'(N - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: registered zero test of the current evaluation sum
    always_ff @(posedge clk) begin
        zero_p0 <= (sum == '0);
        pos_p0  <= k_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_cnt  <= '0;
            k_cnt     <= '0;
            r0        <= '0;
            busy      <= 1'b0;
            vld_p0    <= 1'b0;
            err_valid <= 1'b0;
            err_pos   <= '0;
            err_flag  <= 1'b0;
            done_arm  <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            loc_deg   <= '0;
            fail      <= 1'b0;
        end else begin
            state    <= state_nxt;
            vld_p0   <= (state == SEARCH);
            done_arm <= (state == DONE);
            done     <= done_arm;
            k_cnt    <= (state == SEARCH) ? k_cnt + M'(1) : '0;
            if (state == LOAD) load_cnt <= load_cnt + LCNT_W'(1);
            if (state == LOAD && loc_coef != '0) loc_deg <= 6'(load_cnt);
            // Stage p1: position report and root count
            err_valid <= vld_p0;
            err_flag  <= vld_p0 & zero_p0;
            if (vld_p0) err_pos <= pos_p0;
            if (vld_p0 && zero_p0) err_cnt <= sat_inc(err_cnt);
            if (done_arm) begin
                busy <= 1'b0;
                fail <= (err_cnt != loc_deg);
            end
            if (start_acc) begin
                r0       <= loc_coef;
                load_cnt <= LCNT_W'(1);
                busy     <= 1'b1;
                err_cnt  <= '0;
                loc_deg  <= '0;
                fail     <= 1'b0;
            end
        end
    end

endmodule
